// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: byte width,
// maximum source count and the arbiter state encoding.
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after i_ptr (wrapping) as a one-hot vector plus its index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan NUM_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ message sources.
// A grant lasts for a whole message (until the last byte is accepted or the
// owner drops req). Define TX_ARB_TIMEOUT_EN to enable the idle-owner
// watchdog that revokes a stalled grant after TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [BYTE_W*NUM_REQ-1:0] src_data,
    input  logic [NUM_REQ-1:0]        src_valid,
    input  logic [NUM_REQ-1:0]        src_last,
    output logic [NUM_REQ-1:0]        src_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      new_tx_data,
    input  logic                      tx_busy,
    output logic                      timeout_err
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_src_ready;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_last;
    logic [BYTE_W-1:0]  r_tx_data;
    logic               r_new_tx_data;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [BYTE_W-1:0]  w_own_data;
    logic               w_own_valid;
    logic               w_own_req;
    logic               w_own_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Owner's signals are selected through the one-hot grant.
    always_comb begin
        w_own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_own_data = src_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign w_own_valid = |(src_valid & r_gnt);
    assign w_own_req   = |(req & r_gnt);
    assign w_own_last  = |(src_last & r_gnt);
    assign w_next_ptr  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

`ifdef TX_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wd;
    logic        r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with registered grant, strobe, ready and data outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_src_ready   <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_last        <= 1'b0;
            r_tx_data     <= '0;
            r_new_tx_data <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_new_tx_data <= 1'b0;
            r_src_ready   <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_gnt;
                        r_owner <= w_pick_idx;
                        r_state <= SEND;
`ifdef TX_ARB_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end
                end
                SEND: begin
                    if (w_own_valid && !tx_busy) begin
                        r_tx_data     <= w_own_data;
                        r_new_tx_data <= 1'b1;
                        r_src_ready   <= r_gnt;
                        r_last        <= w_own_last;
                        r_state       <= GAP;
`ifdef TX_ARB_TIMEOUT_EN
                        r_wd          <= '0;
`endif
                    end else if (!w_own_req && !w_own_valid) begin
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
`ifdef TX_ARB_TIMEOUT_EN
                    end else if (!w_own_valid && !tx_busy) begin
                        if (r_wd == WD_LIMIT) begin
                            r_gnt         <= '0;
                            r_rr_ptr      <= w_next_ptr;
                            r_timeout_err <= 1'b1;
                            r_state       <= IDLE;
                        end else begin
                            r_wd <= r_wd + 16'd1;
                        end
`endif
                    end
                end
                GAP: begin
                    if (r_last) begin
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else begin
                        r_state <= SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign src_ready   = r_src_ready;
    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed/randomized bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=15).
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef logic [7:0] msg_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  src_valid = '0;
    logic [3:0]  src_last = '0;
    logic [31:0] src_data = '0;
    logic        tx_busy = 1'b0;
    logic [3:0]  gnt;
    logic [3:0]  src_ready;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int exp_strobes = 0;
    int obs_strobes = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: first request at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic msg_t rand_msg(input int n);
        msg_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
        return m;
    endfunction

    // Invariants checked every cycle plus a count of all send strobes.
    always @(posedge clk) begin
        #1;
        if (new_tx_data === 1'b1) obs_strobes++;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        chk("ready_outside_gnt", 32'(src_ready & ~gnt), 0);
        chk("strobe_vs_ready", 32'(new_tx_data), 32'(|src_ready));
    end

    task automatic wait_grant(input int g);
        int k = 0;
        do begin
            tick();
            k++;
        end while (gnt === '0 && k < 20);
        chk("gnt_latency", k, 1);
        chk("gnt_value", 32'(gnt), 32'(1) << g);
    endtask

    // Source g delivers msg (first stop_after bytes), then withdraws.
    task automatic serve(input int g, input msg_t msg, input int stop_after, input bit keep_req);
        int k;
        int n = msg.size();
        for (int i = 0; i < stop_after; i++) begin
            src_data[8*g +: 8] = msg[i];
            src_valid[g] = 1'b1;
            src_last[g] = (i == n - 1);
            exp_strobes++;
            k = 0;
            do begin
                tick();
                k++;
            end while (src_ready[g] !== 1'b1 && k < 50);
            chk("byte_latency", k, (i == 0) ? 1 : 2);
            chk("src_ready", 32'(src_ready[g]), 1);
            chk("tx_data", 32'(tx_data), 32'(msg[i]));
            chk("new_tx_data", 32'(new_tx_data), 1);
        end
        src_valid[g] = 1'b0;
        src_last[g] = 1'b0;
        if (!keep_req) req[g] = 1'b0;
        if (stop_after < n) begin
            tick();
            chk("gnt_hold_after_drop", 32'(gnt), 32'(1) << g);
        end
        tick();
        chk("gnt_release", 32'(gnt), 0);
        model_ptr = (g + 1) % N;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_ready"}, 32'(src_ready), 0);
        chk({tag, "_txdata"}, 32'(tx_data), 0);
        chk({tag, "_strobe"}, 32'(new_tx_data), 0);
        chk({tag, "_timeout"}, 32'(timeout_err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        msg_t m;
        int g;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk("idle_no_gnt", 32'(gnt), 0);

        // Single source "ABC"
        req[0] = 1'b1;
        wait_grant(pick(req, model_ptr));
        m.delete();
        m.push_back(8'h41);
        m.push_back(8'h42);
        m.push_back(8'h43);
        serve(0, m, 3, 1'b0);

        // Contention from rr_ptr=0, then wrap and fair re-grant
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_ptr = 0;
        req = 4'b1010;
        g = pick(req, model_ptr);
        wait_grant(g);
        m = rand_msg($urandom_range(1, 4));
        serve(g, m, m.size(), 1'b0);
        g = pick(req, model_ptr);
        wait_grant(g);
        req[1] = 1'b1;
        m = rand_msg($urandom_range(1, 4));
        serve(g, m, m.size(), 1'b1);
        g = pick(req, model_ptr);
        wait_grant(g);
        req[3] = 1'b0;
        m = rand_msg($urandom_range(1, 4));
        serve(g, m, m.size(), 1'b0);

        // Mid-message drop with another requester waiting
        req = 4'b0101;
        g = pick(req, model_ptr);
        wait_grant(g);
        m = rand_msg(5);
        serve(g, m, 2, 1'b0);
        g = pick(req, model_ptr);
        wait_grant(g);
        m = rand_msg($urandom_range(1, 4));
        serve(g, m, m.size(), 1'b0);

        // Backpressure: tx_busy held for 20 cycles
        req[3] = 1'b1;
        g = pick(req, model_ptr);
        wait_grant(g);
        tx_busy = 1'b1;
        m = rand_msg(1);
        src_data[8*g +: 8] = m[0];
        src_valid[g] = 1'b1;
        src_last[g] = 1'b1;
        exp_strobes++;
        repeat (20) begin
            tick();
            chk("bp_no_strobe", {27'd0, new_tx_data, src_ready}, 0);
        end
        tx_busy = 1'b0;
        tick();
        chk("bp_ready", 32'(src_ready), 32'(1) << g);
        chk("bp_strobe", 32'(new_tx_data), 1);
        chk("bp_data", 32'(tx_data), 32'(m[0]));
        src_valid[g] = 1'b0;
        src_last[g] = 1'b0;
        req[g] = 1'b0;
        tick();
        chk("bp_release", 32'(gnt), 0);
        model_ptr = (g + 1) % N;

        // Reset in the middle of a message
        req[1] = 1'b1;
        g = pick(req, model_ptr);
        wait_grant(g);
        m = rand_msg(3);
        src_data[8*g +: 8] = m[0];
        src_valid[g] = 1'b1;
        exp_strobes++;
        tick();
        chk("pre_rst_accept", 32'(src_ready), 32'(1) << g);
        src_data[8*g +: 8] = m[1];
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'(1) << g);
        rst = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst = 1'b1;
        src_valid = '0;
        src_last = '0;
        req = 4'b1000;
        model_ptr = 0;
        g = pick(req, model_ptr);
        wait_grant(g);
        m = rand_msg(2);
        serve(g, m, 2, 1'b0);

        // Stalled owner: watchdog or indefinite hold
        req[0] = 1'b1;
        g = pick(req, model_ptr);
        wait_grant(g);
`ifdef TX_ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("wd_pulse", 32'(timeout_err), (i == 15) ? 1 : 0);
            chk("wd_gnt", 32'(gnt), (i == 15) ? 0 : 32'(1) << g);
        end
        model_ptr = (g + 1) % N;
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 0);
        chk("wd_regrant", 32'(gnt), 32'(1) << pick(req, model_ptr));
`else
        repeat (40) begin
            tick();
            chk("hold_gnt", 32'(gnt), 32'(1) << g);
            chk("hold_no_timeout", 32'(timeout_err), 0);
        end
`endif
        req[0] = 1'b0;
        tick();
        chk("stall_release", 32'(gnt), 0);

        tick();
        tick();
        chk("strobe_count", obs_strobes, exp_strobes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
